// File: rtl/dispatch_pkg.sv
// Shared types for the rename/dispatch stage: dispatch packet layout and branch FSM states.
// Widths here match the rename_dispatch_unit parameter defaults.
package dispatch_pkg;

    localparam int DP_XLEN       = 32;
    localparam int DP_NUM_AREGS  = 32;
    localparam int DP_TAG_W      = 6;
    localparam int DP_NUM_QUEUES = 4;
    localparam int DP_PAYLOAD_W  = 64;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        BR_WAIT = 1'b1
    } branch_state_e;

    typedef struct packed {
        logic                    rs1_rdy;
        logic [DP_TAG_W-1:0]     rs1_tag;
        logic [DP_XLEN-1:0]      rs1_data;
        logic                    rs2_rdy;
        logic [DP_TAG_W-1:0]     rs2_tag;
        logic [DP_XLEN-1:0]      rs2_data;
        logic [DP_TAG_W-1:0]     rd_tag;
        logic                    rd_we;
        logic [DP_PAYLOAD_W-1:0] payload;
    } dispatch_pkt_t;

endpackage

// File: rtl/tag_free_list.sv
// Circular FIFO of free rename tags, reset full with tags 0..DEPTH-1.
// head/empty are combinational from state; pop/push take effect at the clock edge.
// Pushes into a full list are dropped unless a pop frees a slot in the same cycle.
module tag_free_list #(
    parameter int DEPTH = 64,
    parameter int W     = 6,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pop,
    input  logic          push,
    input  logic [W-1:0]  push_tag,
    output logic [W-1:0]  head,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;
    logic          push_ok;

    assign head    = mem_q[rd_ptr_q];
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & ((count_q != CW'(DEPTH)) | pop_ok);

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_tag;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({pop_ok, push_ok})
            2'b10:   count_d = count_q - CW'(1);
            2'b01:   count_d = count_q + CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= W'(i);
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= CW'(DEPTH);
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/rename_dispatch_unit.sv
// Renames rd through a tag free list/RST, resolves sources (regfile, RST or CDB forward), dispatches to an issue queue.
// Latency: one cycle from fire to out_valid/out_pkt; redirect pulses one cycle after the resolving CDB beat.
// Backpressure: in_ready drops for a full target queue, tag exhaustion, or while waiting on an unresolved branch.
module rename_dispatch_unit
    import dispatch_pkg::*;
#(
    parameter int XLEN       = DP_XLEN,
    parameter int NUM_AREGS  = DP_NUM_AREGS,
    parameter int TAG_W      = DP_TAG_W,
    parameter int NUM_QUEUES = DP_NUM_QUEUES,
    parameter int PAYLOAD_W  = DP_PAYLOAD_W,
    localparam int AW        = $clog2(NUM_AREGS),
    localparam int QW        = $clog2(NUM_QUEUES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         in_rs1,
    input  logic [AW-1:0]         in_rs2,
    input  logic [AW-1:0]         in_rd,
    input  logic                  in_rd_we,
    input  logic [QW-1:0]         in_queue,
    input  logic                  in_is_branch,
    input  logic [PAYLOAD_W-1:0]  in_payload,
    input  logic [NUM_QUEUES-1:0] q_full,
    input  logic                  cdb_valid,
    input  logic [TAG_W-1:0]      cdb_tag,
    input  logic [XLEN-1:0]       cdb_data,
    input  logic                  cdb_branch,
    input  logic                  cdb_taken,
    output logic [NUM_QUEUES-1:0] out_valid,
    output dispatch_pkt_t         out_pkt,
    output logic                  redirect,
    output logic                  redirect_taken
);

    localparam int NUM_TAGS = 2 ** TAG_W;
    localparam int CW       = $clog2(NUM_TAGS + 1);

    typedef struct packed {
        logic             rdy;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  data;
    } src_t;

    branch_state_e         state_q, state_d;
    logic [NUM_AREGS-1:0]  rst_vld_q, rst_vld_d;
    logic [TAG_W-1:0]      rst_tag_q [NUM_AREGS];
    logic [TAG_W-1:0]      rst_tag_d [NUM_AREGS];
    logic [XLEN-1:0]       regfile_q [NUM_AREGS];
    logic [XLEN-1:0]       regfile_d [NUM_AREGS];
    logic [NUM_QUEUES-1:0] out_valid_q, out_valid_d;
    dispatch_pkt_t         out_pkt_q, out_pkt_d;
    logic                  redirect_q, redirect_d;
    logic                  redirect_taken_q, redirect_taken_d;

    logic                  need_tag;
    logic                  fire;
    logic                  fl_empty;
    logic [TAG_W-1:0]      fl_head;
    logic [CW-1:0]         fl_count;
    src_t                  rs1_src;
    src_t                  rs2_src;

    // Sources read the pre-rename mapping, so rs==rd of one instruction sees the old producer.
    function automatic src_t resolve(input logic             is_zero,
                                     input logic             pend,
                                     input logic [TAG_W-1:0] tag,
                                     input logic [XLEN-1:0]  rf_data,
                                     input logic             cdb_hit,
                                     input logic [XLEN-1:0]  fwd_data);
        src_t s;
        s = '0;
        if (is_zero) begin
            s.rdy = 1'b1;
        end else if (pend && cdb_hit) begin
            s.rdy  = 1'b1;
            s.tag  = tag;
            s.data = fwd_data;
        end else if (pend) begin
            s.tag = tag;
        end else begin
            s.rdy  = 1'b1;
            s.data = rf_data;
        end
        return s;
    endfunction

    assign need_tag = in_rd_we & (in_rd != '0);
    assign in_ready = (state_q == RUN) & ~q_full[in_queue] & (~need_tag | ~fl_empty);
    assign fire     = in_valid & in_ready;

    assign rs1_src = resolve(in_rs1 == '0, rst_vld_q[in_rs1], rst_tag_q[in_rs1], regfile_q[in_rs1],
                             cdb_valid && (cdb_tag == rst_tag_q[in_rs1]), cdb_data);
    assign rs2_src = resolve(in_rs2 == '0, rst_vld_q[in_rs2], rst_tag_q[in_rs2], regfile_q[in_rs2],
                             cdb_valid && (cdb_tag == rst_tag_q[in_rs2]), cdb_data);

    tag_free_list #(
        .DEPTH (NUM_TAGS),
        .W     (TAG_W)
    ) u_free_list (
        .clk      (clk),
        .rst      (rst),
        .pop      (fire & need_tag),
        .push     (cdb_valid),
        .push_tag (cdb_tag),
        .head     (fl_head),
        .empty    (fl_empty),
        .count    (fl_count)
    );

    always_comb begin
        assert (fl_empty == (fl_count == '0));
    end

    // CDB writeback first, then a same-cycle rename of the same register overrides the RST entry.
    always_comb begin
        rst_vld_d = rst_vld_q;
        rst_tag_d = rst_tag_q;
        regfile_d = regfile_q;
        if (cdb_valid) begin
            for (int r = 1; r < NUM_AREGS; r++) begin
                if (rst_vld_q[r] && (rst_tag_q[r] == cdb_tag)) begin
                    rst_vld_d[r] = 1'b0;
                    regfile_d[r] = cdb_data;
                end
            end
        end
        if (fire && need_tag) begin
            rst_vld_d[in_rd] = 1'b1;
            rst_tag_d[in_rd] = fl_head;
        end
    end

    always_comb begin
        out_valid_d = '0;
        out_pkt_d   = out_pkt_q;
        if (fire) begin
            out_valid_d        = {{(NUM_QUEUES-1){1'b0}}, 1'b1} << in_queue;
            out_pkt_d.rs1_rdy  = rs1_src.rdy;
            out_pkt_d.rs1_tag  = rs1_src.tag;
            out_pkt_d.rs1_data = rs1_src.data;
            out_pkt_d.rs2_rdy  = rs2_src.rdy;
            out_pkt_d.rs2_tag  = rs2_src.tag;
            out_pkt_d.rs2_data = rs2_src.data;
            out_pkt_d.rd_tag   = need_tag ? fl_head : '0;
            out_pkt_d.rd_we    = need_tag;
            out_pkt_d.payload  = in_payload;
        end
    end

    always_comb begin
        state_d          = state_q;
        redirect_d       = 1'b0;
        redirect_taken_d = 1'b0;
        case (state_q)
            RUN: begin
                if (fire && in_is_branch) begin
                    state_d = BR_WAIT;
                end
            end
            BR_WAIT: begin
                if (cdb_valid && cdb_branch) begin
                    state_d          = RUN;
                    redirect_d       = 1'b1;
                    redirect_taken_d = cdb_taken;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= RUN;
            rst_vld_q        <= '0;
            out_valid_q      <= '0;
            out_pkt_q        <= '0;
            redirect_q       <= 1'b0;
            redirect_taken_q <= 1'b0;
            for (int r = 0; r < NUM_AREGS; r++) begin
                rst_tag_q[r] <= '0;
                regfile_q[r] <= '0;
            end
        end else begin
            state_q          <= state_d;
            rst_vld_q        <= rst_vld_d;
            rst_tag_q        <= rst_tag_d;
            regfile_q        <= regfile_d;
            out_valid_q      <= out_valid_d;
            out_pkt_q        <= out_pkt_d;
            redirect_q       <= redirect_d;
            redirect_taken_q <= redirect_taken_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pkt        = out_pkt_q;
    assign redirect       = redirect_q;
    assign redirect_taken = redirect_taken_q;

endmodule

// File: tb/tb_rename_dispatch_unit.sv
// Directed bench for rename_dispatch_unit: renaming, forwarding, stalls, branch wait and reset.
module tb_rename_dispatch_unit;
    import dispatch_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [4:0]    in_rs1, in_rs2, in_rd;
    logic          in_rd_we;
    logic [1:0]    in_queue;
    logic          in_is_branch;
    logic [63:0]   in_payload;
    logic [3:0]    q_full;
    logic          cdb_valid;
    logic [5:0]    cdb_tag;
    logic [31:0]   cdb_data;
    logic          cdb_branch;
    logic          cdb_taken;
    logic [3:0]    out_valid;
    dispatch_pkt_t out_pkt;
    logic          redirect;
    logic          redirect_taken;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    rename_dispatch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_rs1         (in_rs1),
        .in_rs2         (in_rs2),
        .in_rd          (in_rd),
        .in_rd_we       (in_rd_we),
        .in_queue       (in_queue),
        .in_is_branch   (in_is_branch),
        .in_payload     (in_payload),
        .q_full         (q_full),
        .cdb_valid      (cdb_valid),
        .cdb_tag        (cdb_tag),
        .cdb_data       (cdb_data),
        .cdb_branch     (cdb_branch),
        .cdb_taken      (cdb_taken),
        .out_valid      (out_valid),
        .out_pkt        (out_pkt),
        .redirect       (redirect),
        .redirect_taken (redirect_taken)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_rd_we = 1'b0;
        in_queue = '0; in_is_branch = 1'b0; in_payload = '0; q_full = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; cdb_branch = 1'b0; cdb_taken = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Presents one instruction, expects it to be accepted, returns 1 time unit after the firing edge.
    task automatic issue(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic we, input logic [1:0] q, input logic br, input logic [63:0] pl);
        in_valid = 1'b1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd; in_rd_we = we;
        in_queue = q; in_is_branch = br; in_payload = pl;
        #1;
        check_eq("fire_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; in_is_branch = 1'b0; in_rd_we = 1'b0;
        cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_taken = 1'b0;
    endtask

    task automatic cdb_send(input logic [5:0] tag, input logic [31:0] data, input logic br, input logic taken);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data; cdb_branch = br; cdb_taken = taken;
        tick();
        cdb_valid = 1'b0; cdb_branch = 1'b0; cdb_taken = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_redirect", 64'({redirect, redirect_taken}), 64'd0);
        check_eq("rst_pkt_zero", 64'(out_pkt == '0), 64'd1);
        check_eq("rst_fl_count", 64'(dut.u_free_list.count_q), 64'd64);
        check_eq("rst_in_ready", 64'(in_ready), 64'd1);
        rst = 1'b0;

        // add x3,x1,x2 -> queue 2
        issue(5'd1, 5'd2, 5'd3, 1'b1, 2'd2, 1'b0, 64'hDEAD_BEEF_0000_0001);
        check_eq("add_out_valid", 64'(out_valid), 64'h4);
        check_eq("add_rd_tag", 64'(out_pkt.rd_tag), 64'd0);
        check_eq("add_rd_we", 64'(out_pkt.rd_we), 64'd1);
        check_eq("add_rs1", 64'({out_pkt.rs1_rdy, out_pkt.rs1_data}), 64'h1_0000_0000);
        check_eq("add_rs2", 64'({out_pkt.rs2_rdy, out_pkt.rs2_data}), 64'h1_0000_0000);
        check_eq("add_payload", out_pkt.payload, 64'hDEAD_BEEF_0000_0001);
        tick();
        check_eq("strobe_one_cycle", 64'(out_valid), 64'd0);

        // x5 <= tag1, then x6 <= x5+x5 depends on tag1
        issue(5'd0, 5'd0, 5'd5, 1'b1, 2'd0, 1'b0, 64'd1);
        check_eq("x5_rd_tag", 64'(out_pkt.rd_tag), 64'd1);
        issue(5'd5, 5'd5, 5'd6, 1'b1, 2'd1, 1'b0, 64'd2);
        check_eq("dep_out_valid", 64'(out_valid), 64'h2);
        check_eq("dep_rs1", 64'({out_pkt.rs1_rdy, out_pkt.rs1_tag}), 64'h01);
        check_eq("dep_rs2", 64'({out_pkt.rs2_rdy, out_pkt.rs2_tag}), 64'h01);
        check_eq("dep_rd_tag", 64'(out_pkt.rd_tag), 64'd2);

        // writeback tag1 then read x5 from the regfile; x3 still pending on tag0
        cdb_send(6'd1, 32'h55, 1'b0, 1'b0);
        issue(5'd5, 5'd3, 5'd8, 1'b1, 2'd3, 1'b0, 64'd3);
        check_eq("wb_rs1", 64'({out_pkt.rs1_rdy, out_pkt.rs1_data}), 64'h1_0000_0055);
        check_eq("wb_rs2", 64'({out_pkt.rs2_rdy, out_pkt.rs2_tag}), 64'h00);
        check_eq("wb_rd_tag", 64'(out_pkt.rd_tag), 64'd3);

        // same-cycle CDB forward of tag0 (x3)
        cdb_valid = 1'b1; cdb_tag = 6'd0; cdb_data = 32'hABCD;
        issue(5'd3, 5'd3, 5'd9, 1'b1, 2'd0, 1'b0, 64'd4);
        check_eq("fwd_rs1", 64'({out_pkt.rs1_rdy, out_pkt.rs1_data}), 64'h1_0000_ABCD);
        check_eq("fwd_rs2", 64'({out_pkt.rs2_rdy, out_pkt.rs2_data}), 64'h1_0000_ABCD);
        check_eq("fwd_rd_tag", 64'(out_pkt.rd_tag), 64'd4);
        issue(5'd3, 5'd0, 5'd0, 1'b0, 2'd0, 1'b0, 64'd5);
        check_eq("fwd_rf_written", 64'({out_pkt.rs1_rdy, out_pkt.rs1_data}), 64'h1_0000_ABCD);
        check_eq("nowrite_rd", 64'({out_pkt.rd_we, out_pkt.rd_tag}), 64'd0);

        // CDB tag2 (x6) and rename of x6 in the same cycle: new mapping wins
        cdb_valid = 1'b1; cdb_tag = 6'd2; cdb_data = 32'h66;
        issue(5'd6, 5'd0, 5'd6, 1'b1, 2'd1, 1'b0, 64'd6);
        check_eq("race_rs1", 64'({out_pkt.rs1_rdy, out_pkt.rs1_data}), 64'h1_0000_0066);
        check_eq("race_rd_tag", 64'(out_pkt.rd_tag), 64'd5);
        issue(5'd6, 5'd0, 5'd0, 1'b0, 2'd2, 1'b0, 64'd7);
        check_eq("race_new_map", 64'({out_pkt.rs1_rdy, out_pkt.rs1_tag}), 64'h05);

        // queue back-pressure
        q_full = 4'b0010; in_valid = 1'b1; in_queue = 2'd1; in_rd = 5'd7; in_rd_we = 1'b1;
        #1;
        check_eq("qfull_ready", 64'(in_ready), 64'd0);
        tick();
        check_eq("qfull_no_out", 64'(out_valid), 64'd0);
        in_queue = 2'd2;
        #1;
        check_eq("other_q_ready", 64'(in_ready), 64'd1);
        idle_inputs();
        tick();

        // tag exhaustion
        do_reset();
        for (int i = 0; i < 64; i++) begin
            logic [4:0] rd;
            rd = 5'((i % 31) + 1);
            issue(rd, 5'd0, rd, 1'b1, 2'd0, 1'b0, 64'(i));
            check_eq("exh_rd_tag", 64'(out_pkt.rd_tag), 64'(i));
            if (i == 31) begin
                check_eq("self_old_map", 64'({out_pkt.rs1_rdy, out_pkt.rs1_tag}), 64'h00);
            end
        end
        in_valid = 1'b1; in_rd_we = 1'b1; in_rd = 5'd20; in_rs1 = 5'd10;
        #1;
        check_eq("exh_stall", 64'(in_ready), 64'd0);
        in_rd_we = 1'b0;
        #1;
        check_eq("exh_nowrite_ok", 64'(in_ready), 64'd1);
        in_rd_we = 1'b1; in_rd = 5'd0;
        #1;
        check_eq("exh_x0_ok", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        cdb_send(6'd40, 32'h4040, 1'b0, 1'b0);
        issue(5'd10, 5'd0, 5'd20, 1'b1, 2'd3, 1'b0, 64'd65);
        check_eq("exh_recycled_tag", 64'(out_pkt.rd_tag), 64'd40);
        check_eq("exh_rs1", 64'({out_pkt.rs1_rdy, out_pkt.rs1_data}), 64'h1_0000_4040);
        check_eq("exh_out_valid", 64'(out_valid), 64'h8);

        // branch stall, taken then not taken
        do_reset();
        issue(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 64'hB0);
        check_eq("br_out_valid", 64'(out_valid), 64'h1);
        check_eq("br_wait_ready", 64'(in_ready), 64'd0);
        cdb_send(6'd3, 32'h0, 1'b0, 1'b0);
        check_eq("br_nonbr_cdb", 64'({redirect, in_ready}), 64'd0);
        cdb_send(6'd0, 32'h0, 1'b1, 1'b1);
        check_eq("br_redirect", 64'(redirect), 64'd1);
        check_eq("br_taken", 64'(redirect_taken), 64'd1);
        check_eq("br_resume_ready", 64'(in_ready), 64'd1);
        tick();
        check_eq("br_pulse_end", 64'(redirect), 64'd0);
        issue(5'd0, 5'd0, 5'd0, 1'b0, 2'd1, 1'b1, 64'hB1);
        check_eq("br2_wait_ready", 64'(in_ready), 64'd0);
        cdb_send(6'd0, 32'h0, 1'b1, 1'b0);
        check_eq("br2_redirect", 64'({redirect, redirect_taken}), 64'h2);
        cdb_send(6'd0, 32'h0, 1'b1, 1'b1);
        check_eq("run_cdb_br_ignored", 64'(redirect), 64'd0);

        // reset while waiting on a branch
        issue(5'd0, 5'd0, 5'd4, 1'b1, 2'd1, 1'b0, 64'h9);
        issue(5'd0, 5'd0, 5'd0, 1'b0, 2'd0, 1'b1, 64'hB2);
        check_eq("pre_rst_ready", 64'(in_ready), 64'd0);
        check_eq("pre_rst_count", 64'(dut.u_free_list.count_q), 64'd63);
        #2;
        rst = 1'b1;
        #1;
        check_eq("brst_out_valid", 64'(out_valid), 64'd0);
        check_eq("brst_pkt_zero", 64'(out_pkt == '0), 64'd1);
        check_eq("brst_redirect", 64'({redirect, redirect_taken}), 64'd0);
        check_eq("brst_fl_count", 64'(dut.u_free_list.count_q), 64'd64);
        check_eq("brst_ready", 64'(in_ready), 64'd1);
        tick();
        rst = 1'b0;
        issue(5'd4, 5'd0, 5'd4, 1'b1, 2'd2, 1'b0, 64'hA);
        check_eq("post_rst_map", 64'({out_pkt.rs1_rdy, out_pkt.rd_tag}), 64'h40);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
